// File: rtl/acc_ctrl_pkg.sv
// rtl/acc_ctrl_pkg.sv - shared encodings for the accumulator processor control unit
// Holds opcode values, the 3-bit FSM state encoding, ALUOp and ACCSrc encodings,
// and a helper that maps an ALU-class opcode onto its ALUOp.
package acc_ctrl_pkg;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_ADDI  = 4'h7;
  localparam logic [3:0] OP_LI    = 4'h8;
  localparam logic [3:0] OP_BEQZ  = 4'h9;
  localparam logic [3:0] OP_BNEZ  = 4'hA;
  localparam logic [3:0] OP_JUMP  = 4'hB;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_MEM_WR = 3'd4,
    ST_EXEC   = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] ACC_FROM_ALU = 2'd0;
  localparam logic [1:0] ACC_FROM_MEM = 2'd1;
  localparam logic [1:0] ACC_FROM_IMM = 2'd2;

  function automatic logic [1:0] alu_op_for(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/acc_ctrl_wait_timer.sv
// rtl/acc_ctrl_wait_timer.sv - memory-wait counter with timeout compare
// Ports: clk, reset (async active-low), clear (restart count), count_en (waiting
// cycle), timeout (count_en while count == MEM_WAIT_MAX; never when MEM_WAIT_MAX == 0).
module acc_ctrl_wait_timer #(
  parameter int WAIT_W       = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);

  localparam logic [WAIT_W-1:0] LIMIT      = WAIT_W'(MEM_WAIT_MAX);
  localparam bit                TIMEOUT_EN = (MEM_WAIT_MAX != 0);

  logic [WAIT_W-1:0] cnt;

  // Saturates so a disabled timeout cannot wrap back through the limit value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (count_en && (cnt != '1))
      cnt <= cnt + WAIT_W'(1);
  end

  assign timeout = TIMEOUT_EN && count_en && (cnt == LIMIT);

endmodule

// File: rtl/acc_ctrl_fsm.sv
// rtl/acc_ctrl_fsm.sv - multi-cycle fetch/decode/execute control unit
// Inputs: clk, reset (async active-low), opcode (IR[15:12], sampled in DECODE),
//   acc_zero, mem_ready. Outputs: PC/IR/memory/ACC strobes and selects, halted,
//   sticky illegal_op and bus_error.
// Optional macro ACC_CTRL_PERF_EN adds cycle_count and instr_count [PERF_W-1:0].
module acc_ctrl_fsm
  import acc_ctrl_pkg::*;
#(
  parameter int OPCODE_W     = 4,
  parameter int WAIT_W       = 4,
  parameter int MEM_WAIT_MAX = 15
`ifdef ACC_CTRL_PERF_EN
  ,
  parameter int PERF_W       = 32
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                acc_zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCSrc,
  output logic                IRWrite,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                ACCWrite,
  output logic [1:0]          ACCSrc,
  output logic [1:0]          ALUOp,
  output logic                ALUSrcB,
  output logic                halted,
  output logic                illegal_op,
  output logic                bus_error
`ifdef ACC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]   cycle_count,
  output logic [PERF_W-1:0]   instr_count
`endif
);

  state_t state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic wait_state, count_en, timeout, dec_illegal;

  assign wait_state = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
  assign count_en   = wait_state && !mem_ready;

  acc_ctrl_wait_timer #(
    .WAIT_W       (WAIT_W),
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_d != state_q),
    .count_en (count_en),
    .timeout  (timeout)
  );

  // State register, latched opcode and sticky status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RESET;
      op_q       <= '0;
      illegal_op <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE)
        op_q <= opcode;
      if (dec_illegal)
        illegal_op <= 1'b1;
      if (timeout)
        bus_error <= 1'b1;
    end
  end

  // Next-state logic; mem_ready takes priority over the timeout on the limit cycle.
  always_comb begin
    state_d     = state_q;
    dec_illegal = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)    state_d = ST_DECODE;
        else if (timeout) state_d = ST_HALT;
      end
      ST_DECODE: begin
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR:       state_d = ST_MEM_RD;
          OP_STORE:                                     state_d = ST_MEM_WR;
          OP_ADDI, OP_LI, OP_BEQZ, OP_BNEZ, OP_JUMP:    state_d = ST_EXEC;
          OP_HALT:                                      state_d = ST_HALT;
          default: begin
            state_d     = ST_HALT;
            dec_illegal = 1'b1;
          end
        endcase
      end
      ST_MEM_RD, ST_MEM_WR: begin
        if (mem_ready)    state_d = ST_FETCH;
        else if (timeout) state_d = ST_HALT;
      end
      ST_EXEC:  state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  // Output decode; outputs follow state_q so an async reset drops requests at once.
  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ACCWrite = 1'b0;
    ACCSrc   = ACC_FROM_ALU;
    ALUOp    = ALU_ADD;
    ALUSrcB  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      ST_MEM_RD: begin
        MemRead  = 1'b1;
        IorD     = 1'b1;
        ACCWrite = mem_ready;
        if (op_q == OP_LOAD) begin
          ACCSrc = ACC_FROM_MEM;
        end else begin
          ACCSrc = ACC_FROM_ALU;
          ALUOp  = alu_op_for(op_q);
        end
      end
      ST_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      ST_EXEC: begin
        case (op_q)
          OP_ADDI: begin
            ACCWrite = 1'b1;
            ALUSrcB  = 1'b1;
          end
          OP_LI: begin
            ACCWrite = 1'b1;
            ACCSrc   = ACC_FROM_IMM;
          end
          OP_BEQZ: begin
            PCWrite = acc_zero;
            PCSrc   = acc_zero;
          end
          OP_BNEZ: begin
            PCWrite = !acc_zero;
            PCSrc   = !acc_zero;
          end
          OP_JUMP: begin
            PCWrite = 1'b1;
            PCSrc   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

`ifdef ACC_CTRL_PERF_EN
  // An instruction retires when control returns to FETCH from its last state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if ((state_q != ST_RESET) && (state_q != ST_HALT))
        cycle_count <= cycle_count + PERF_W'(1);
      if (((state_q == ST_MEM_RD) || (state_q == ST_MEM_WR) || (state_q == ST_EXEC)) &&
          (state_d == ST_FETCH))
        instr_count <= instr_count + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// tb/tb_acc_ctrl_fsm.sv - table-driven and directed checks for acc_ctrl_fsm
module tb_acc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       acc_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite, ACCWrite;
  logic [1:0] ACCSrc, ALUOp;
  logic       ALUSrcB, halted, illegal_op, bus_error;
`ifdef ACC_CTRL_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  acc_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .acc_zero   (acc_zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .IRWrite    (IRWrite),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ACCWrite   (ACCWrite),
    .ACCSrc     (ACCSrc),
    .ALUOp      (ALUOp),
    .ALUSrcB    (ALUSrcB),
    .halted     (halted),
    .illegal_op (illegal_op),
    .bus_error  (bus_error)
`ifdef ACC_CTRL_PERF_EN
    ,
    .cycle_count(cycle_count),
    .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        rdy;
    logic        az;
    logic [14:0] want;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  // Bit order: PCWrite PCSrc IRWrite IorD MemRead MemWrite ACCWrite ACCSrc[1:0] ALUOp[1:0] ALUSrcB halted illegal_op bus_error
  function automatic logic [14:0] ex(input bit pcw, pcs, irw, iord, mr, mw, accw,
                                     input bit [1:0] accsrc, aluop,
                                     input bit srcb, halt, ill, be);
    return {pcw, pcs, irw, iord, mr, mw, accw, accsrc, aluop, srcb, halt, ill, be};
  endfunction

  function automatic logic [14:0] rd(input bit accw, input bit [1:0] accsrc, aluop);
    return ex(0, 0, 0, 1, 1, 0, accw, accsrc, aluop, 0, 0, 0, 0);
  endfunction

  // Selects only matter when the strobe that consumes them is active.
  function automatic logic [14:0] mask_for(input logic [14:0] w);
    logic [14:0] m;
    m = '1;
    if (!w[14]) m[13] = 1'b0;
    if (!(w[10] | w[9])) m[11] = 1'b0;
    if (!w[8]) m[7:3] = '0;
    else if (w[7:6] != 2'd0) m[5:3] = '0;
    return m;
  endfunction

  task automatic check_out(input string name, input logic [14:0] w);
    logic [14:0] act, m;
    act = {PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite, ACCWrite, ACCSrc, ALUOp,
           ALUSrcB, halted, illegal_op, bus_error};
    m = mask_for(w);
    checks++;
    if ((act & m) !== (w & m)) begin
      failures++;
      $display("FAIL %s got=%b want=%b mask=%b", name, act, w, m);
    end
  endtask

  task automatic row(input logic [3:0] op, input logic rdy, input logic az,
                     input logic [14:0] w, input string name);
    @(negedge clk);
    opcode    = op;
    mem_ready = rdy;
    acc_zero  = az;
    #1;
    check_out(name, w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_out("reset_outputs", 15'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic add(input logic [3:0] op, input logic rdy, input logic az, input logic [14:0] w);
    vec_t v;
    v.op = op; v.rdy = rdy; v.az = az; v.want = w;
    vecs.push_back(v);
  endtask

  logic [14:0] F, FW, N, RDW, WRW, BR, HI, HB, HH;

  initial begin
    F   = ex(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    FW  = ex(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    N   = 15'd0;
    RDW = rd(0, 0, 0);
    WRW = ex(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    BR  = ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    HI  = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    HB  = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    HH  = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // One row per cycle starting in RESET; opcode is only meaningful in DECODE rows.
    add(4'h8, 1, 0, N);                                        // RESET
    add(4'h8, 1, 0, F);  add(4'h8, 1, 0, N);                   // LI
    add(4'hE, 1, 0, ex(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
    add(4'h3, 1, 0, F);  add(4'h3, 1, 0, N);                   // ADD, 3 wait cycles
    add(4'hE, 0, 0, RDW); add(4'hE, 0, 0, RDW); add(4'hE, 0, 0, RDW);
    add(4'hE, 1, 0, rd(1, 0, 0));
    add(4'h9, 1, 0, F);  add(4'h9, 1, 0, N);  add(4'h9, 1, 1, BR);  // BEQZ taken
    add(4'h9, 1, 0, F);  add(4'h9, 1, 0, N);  add(4'h9, 1, 0, N);   // BEQZ not taken
    add(4'hA, 1, 0, F);  add(4'hA, 1, 0, N);  add(4'hA, 1, 0, BR);  // BNEZ taken
    add(4'hA, 1, 0, F);  add(4'hA, 1, 0, N);  add(4'hA, 1, 1, N);   // BNEZ not taken
    add(4'h2, 1, 0, F);  add(4'h2, 1, 0, N);                   // STORE, one wait
    add(4'h2, 0, 0, WRW); add(4'h2, 1, 0, WRW);
    add(4'h1, 1, 0, F);  add(4'h1, 1, 0, N);  add(4'h1, 1, 0, rd(1, 1, 0));  // LOAD
    add(4'h4, 1, 0, F);  add(4'h4, 1, 0, N);  add(4'h4, 1, 0, rd(1, 0, 1));  // SUB
    add(4'h5, 1, 0, F);  add(4'h5, 1, 0, N);  add(4'h5, 1, 0, rd(1, 0, 2));  // AND
    add(4'h6, 1, 0, F);  add(4'h6, 1, 0, N);  add(4'h6, 1, 0, rd(1, 0, 3));  // OR
    add(4'h7, 1, 0, F);  add(4'h7, 1, 0, N);                   // ADDI
    add(4'h7, 1, 0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    add(4'hB, 1, 0, F);  add(4'hB, 1, 0, N);  add(4'hB, 1, 1, BR);  // JUMP
    add(4'hF, 1, 0, F);  add(4'hF, 1, 0, N);                   // illegal
    add(4'h8, 1, 0, HI); add(4'h8, 1, 1, HI); add(4'h3, 0, 0, HI);

    do_reset();
    for (int i = 0; i < vecs.size(); i++)
      row(vecs[i].op, vecs[i].rdy, vecs[i].az, vecs[i].want, $sformatf("vec%0d", i));

    // Async reset in the middle of a store drops MemWrite without a clock edge.
    do_reset();
    row(4'h2, 1, 0, N, "rst_state");
    row(4'h2, 1, 0, F, "st_fetch");
    row(4'h2, 1, 0, N, "st_decode");
    row(4'h2, 0, 0, WRW, "st_memwr_wait");
    #1;
    reset = 1'b0;
    #1;
    check_out("memwr_async_drop", N);
    @(posedge clk);
    #2;
    reset = 1'b1;
    row(4'h8, 1, 0, N, "after_release_reset_state");
    row(4'h8, 1, 0, F, "after_release_fetch");

    // HALT opcode: halted without illegal_op.
    do_reset();
    row(4'h0, 1, 0, N, "h_rst");
    row(4'h0, 1, 0, F, "h_fetch");
    row(4'h0, 1, 0, N, "h_decode");
    row(4'h8, 1, 0, HH, "halt_op0");
    row(4'h8, 1, 0, HH, "halt_op0_stays");

    // Fetch timeout: 16 unready cycles then HALT with bus_error.
    do_reset();
    row(4'h8, 0, 0, N, "to_rst");
    for (int k = 1; k <= 16; k++)
      row(4'h8, 0, 0, FW, $sformatf("to_wait%0d", k));
    row(4'h8, 1, 0, HB, "timeout_halt");
    row(4'h8, 1, 0, HB, "timeout_halt_stays");

    // Ready on the limit cycle completes the fetch instead.
    do_reset();
    row(4'h8, 0, 0, N, "lim_rst");
    for (int k = 1; k <= 15; k++)
      row(4'h8, 0, 0, FW, $sformatf("lim_wait%0d", k));
    row(4'h8, 1, 0, F, "limit_ready_fetch");
    row(4'h8, 1, 0, N, "limit_ready_decode");
    row(4'h8, 1, 0, ex(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0), "limit_ready_exec");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
